quadrature_decoder: RTL

Front-end stage for the 4-bit up/down counter: turns a pair of raw, asynchronous quadrature-encoder signals (A, B) into the counter's `enable` step pulse and `up_down` direction level. Each channel is synchronised and glitch-filtered; each valid Gray-code transition produces exactly one single-cycle `enable` pulse with a matching direction. Illegal double transitions are flagged and never counted.

---
 rtl/quad_pkg.sv | 59 +++++
 rtl/quadrature_decoder_if.sv | 22 ++
 rtl/quadrature_decoder_glitch_filter.sv | 66 ++++++
 rtl/quadrature_decoder.sv | 98 +++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: direction encoding,
// Gray-code phase constants and the single-step transition classifier.
package quad_pkg;

    // Direction level as presented on up_down.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // {A,B} phases in forward (A leads B) order.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Classification of one filtered-pair transition.
    typedef struct packed {
        logic valid;    // exactly one channel moved
        dir_e dir;      // meaningful only when valid
        logic illegal;  // both channels moved in the same cycle
    } step_t;

    // Position of a phase along the forward sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            PH_00:   pos = 2'd0;
            PH_10:   pos = 2'd1;
            PH_11:   pos = 2'd2;
            default: pos = 2'd3;  // PH_01
        endcase
        return pos;
    endfunction

    // Modulo-4 distance between positions tells the step kind:
    // +1 is forward, -1 (3) is reverse, 2 is a skipped phase, 0 is no move.
    function automatic step_t quad_step(input logic [1:0] old_ab,
                                        input logic [1:0] new_ab);
        step_t      s;
        logic [1:0] delta;
        s     = '{valid: 1'b0, dir: DIR_UP, illegal: 1'b0};
        delta = phase_pos(new_ab) - phase_pos(old_ab);
        case (delta)
            2'd1: begin
                s.valid = 1'b1;
                s.dir   = DIR_UP;
            end
            2'd3: begin
                s.valid = 1'b1;
                s.dir   = DIR_DOWN;
            end
            2'd2:    s.illegal = 1'b1;
            default: s.valid   = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder-side bundle of the quadrature decoder: raw channels and error
// clear in, counter-facing step pulse, direction and error flag out.
interface quadrature_decoder_if;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic enable;
    logic up_down;
    logic err;

    // Drives the encoder channels and consumes the decoded step.
    modport master (
        output a_in, b_in, err_clr,
        input  enable, up_down, err
    );

    // The decoder itself.
    modport slave (
        input  a_in, b_in, err_clr,
        output enable, up_down, err
    );
endinterface

// File: rtl/quadrature_decoder_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a stability filter.
// The filtered bit only follows the synchronised input after it has differed
// for FILTER_CYCLES consecutive cycles. While load is high the filter is
// bypassed so the resting level is captured without a qualification delay.
module glitch_filter #(
    parameter int FILTER_CYCLES = 4  // legal range 1..15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d_in,
    output logic filt_out,
    output logic filt_next
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic [3:0] cnt_q,   cnt_d;

    // Synchroniser shift path for the asynchronous channel input.
    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
    end

    // Stability counter and filtered value update.
    always_comb begin
        // NOTE: defaults first on every path keep this purely combinational; a missed branch would otherwise infer a latch.
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (load) begin
            filt_d = sync2_q;
            cnt_d  = 4'd0;
        end else if (sync2_q == filt_q) begin
            cnt_d  = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
            cnt_d  = 4'd0;
        end else begin
            cnt_d  = cnt_q + 4'd1;
        end
    end

    // State registers; reset discards any partially qualified edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_out  = filt_q;
    assign filt_next = filt_d;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder front end for the up/down counter. Both channels are
// synchronised and glitch-filtered, then each transition of the filtered
// pair is classified: a single-channel move yields one enable pulse with its
// direction, a simultaneous move of both channels sets the sticky error.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_CYCLES = 4  // legal range 1..15
) (
    input logic                 clk,
    input logic                 rst,
    quadrature_decoder_if.slave bus
);

    logic       filt_a, filt_a_next;
    logic       filt_b, filt_b_next;
    logic       load;
    step_t      step;

    logic [1:0] arm_cnt_q, arm_cnt_d;
    logic       armed_q,   armed_d;
    logic       enable_q,  enable_d;
    logic       up_down_q, up_down_d;
    logic       err_q,     err_d;

    // Until armed, the filters track the encoder directly so the resting
    // position after reset is absorbed rather than counted.
    assign load = ~armed_q;

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (bus.a_in),
        .filt_out  (filt_a),
        .filt_next (filt_a_next)
    );

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (bus.b_in),
        .filt_out  (filt_b),
        .filt_next (filt_b_next)
    );

    // The pair being registered this edge against the pair held now.
    assign step = quad_step({filt_a, filt_b}, {filt_a_next, filt_b_next});

    // Arming: the two edges needed to fill the synchroniser plus one load
    // edge into filt, then decode is enabled for good.
    always_comb begin
        arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 2'd1;
        armed_d   = armed_q | (arm_cnt_q == 2'd2);
    end

    // Step pulse, direction and sticky error; a set beats a same-edge clear.
    always_comb begin
        enable_d  = 1'b0;
        up_down_d = up_down_q;
        err_d     = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (armed_q) begin
            if (step.valid) begin
                enable_d  = 1'b1;
                up_down_d = step.dir;
            end
            if (step.illegal) begin
                err_d = 1'b1;
            end
        end
    end

    // Arming state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt_q <= 2'd0;
            armed_q   <= 1'b0;
            enable_q  <= 1'b0;
            up_down_q <= DIR_UP;
            err_q     <= 1'b0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            enable_q  <= enable_d;
            up_down_q <= up_down_d;
            err_q     <= err_d;
        end
    end

    assign bus.enable  = enable_q;
    assign bus.up_down = up_down_q;
    assign bus.err     = err_q;

endmodule
